// File: rtl/speed_ramp.sv
// speed_ramp
//   Multi-channel speed command converter with slew-rate limiting. Each
//   channel turns a signed-magnitude speed code into a real speed magnitude
//   plus a direction bit. The real speed moves toward the command in bounded
//   steps on a shared prescaled tick. A reversal always ramps down to zero
//   before the direction flips.
//
// Ports
//   clk         in   single clock, all state updates on the rising edge
//   reset       in   synchronous, active-high reset
//   bin_speed   in   per-channel codes, channel i at [i*CODE_W +: CODE_W];
//                    the MSB is direction (1 = reverse), the rest is magnitude
//   load        in   per-channel strobe that captures that channel's code
//   real_speed  out  per-channel unsigned speed magnitude, registered
//   direction   out  per-channel current direction (1 = reverse), registered
//   at_target   out  channel output equals its command (combinational)
module speed_ramp #(
  parameter int WIDTH      = 32,
  parameter int CODE_W     = 3,
  parameter int NUM_CH     = 2,
  parameter int SPEED_STEP = 100,
  parameter int RAMP_STEP  = 25,
  parameter int RAMP_DIV   = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_CH*CODE_W-1:0] bin_speed,
  input  logic [NUM_CH-1:0]        load,
  output logic [NUM_CH*WIDTH-1:0]  real_speed,
  output logic [NUM_CH-1:0]        direction,
  output logic [NUM_CH-1:0]        at_target
);

  // The largest commanded magnitude and the ramp step must both be
  // representable in WIDTH bits, so the ramp arithmetic never wraps.
  localparam longint MAX_MAG =
    longint'(SPEED_STEP) * ((longint'(1) << (CODE_W - 1)) - 1);

  if (WIDTH < 63 && (MAX_MAG >> WIDTH) != 0) begin : g_mag_check
    $error("speed_ramp: SPEED_STEP*(2^(CODE_W-1)-1) does not fit in WIDTH");
  end
  if (WIDTH < 63 && (longint'(RAMP_STEP) >> WIDTH) != 0) begin : g_step_check
    $error("speed_ramp: RAMP_STEP does not fit in WIDTH");
  end
  if (RAMP_DIV < 1 || CODE_W < 2 || NUM_CH < 1) begin : g_param_check
    $error("speed_ramp: RAMP_DIV >= 1, CODE_W >= 2 and NUM_CH >= 1 are needed");
  end

  localparam int                CNT_W    = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(RAMP_DIV - 1);
  localparam logic [WIDTH-1:0]  STEP_W   = WIDTH'(RAMP_STEP);
  localparam logic [WIDTH-1:0]  SPEED_W  = WIDTH'(SPEED_STEP);

  typedef enum logic [2:0] {
    HOLD,
    RAMP_UP,
    RAMP_DOWN,
    REVERSE,
    FLIP
  } ramp_state_t;

  // Step size toward the target: the full ramp step, or the remaining gap
  // when that is smaller, so the speed lands exactly on the target.
  function automatic logic [WIDTH-1:0] clamp_step(input logic [WIDTH-1:0] gap);
    return (gap < STEP_W) ? gap : STEP_W;
  endfunction

  logic [CNT_W-1:0] count;
  logic             tick;

  // Shared free-running prescaler. Loads never disturb it, so every channel
  // sees the same tick cadence no matter when its commands arrive.
  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
    end else if (count == CNT_LAST) begin
      count <= '0;
    end else begin
      count <= count + 1'b1;
    end
  end

  assign tick = (count == CNT_LAST);

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    logic [CODE_W-1:0] code;
    logic [CODE_W-2:0] code_mag;
    logic              code_dir;
    logic              tgt_dir;
    logic [WIDTH-1:0]  tgt_mag;
    logic [WIDTH-1:0]  speed;
    logic [WIDTH-1:0]  speed_next;
    logic              dir;
    logic              dir_next;
    logic [WIDTH-1:0]  gap;
    ramp_state_t       state;

    assign code     = bin_speed[i*CODE_W +: CODE_W];
    assign code_dir = code[CODE_W-1];
    assign code_mag = code[CODE_W-2:0];

    // Command register. A new load simply replaces the old target; the ramp
    // continues from wherever the speed currently is.
    always_ff @(posedge clk) begin
      if (reset) begin
        tgt_dir <= 1'b0;
        tgt_mag <= '0;
      end else if (load[i]) begin
        tgt_dir <= code_dir;
        tgt_mag <= WIDTH'(code_mag) * SPEED_W;
      end
    end

    // Output registers only move on tick edges. The next values come from
    // the current command register, so a load landing on a tick edge takes
    // effect from the following tick.
    always_ff @(posedge clk) begin
      if (reset) begin
        speed <= '0;
        dir   <= 1'b0;
      end else if (tick) begin
        speed <= speed_next;
        dir   <= dir_next;
      end
    end

    // The ramp state is recomputed from the registers every cycle. A
    // direction mismatch always takes precedence: ramp the magnitude to
    // zero first, then flip the direction on its own tick.
    always_comb begin
      state      = HOLD;
      speed_next = speed;
      dir_next   = dir;
      gap        = '0;

      if (dir != tgt_dir) begin
        state = (speed == '0) ? FLIP : REVERSE;
      end else if (speed < tgt_mag) begin
        state = RAMP_UP;
      end else if (speed > tgt_mag) begin
        state = RAMP_DOWN;
      end

      case (state)
        RAMP_UP: begin
          gap        = tgt_mag - speed;
          speed_next = speed + clamp_step(gap);
        end
        RAMP_DOWN: begin
          gap        = speed - tgt_mag;
          speed_next = speed - clamp_step(gap);
        end
        REVERSE: begin
          gap        = speed;
          speed_next = speed - clamp_step(gap);
        end
        FLIP: begin
          dir_next = tgt_dir;
        end
        default: begin
          speed_next = speed;
        end
      endcase
    end

    assign real_speed[i*WIDTH +: WIDTH] = speed;
    assign direction[i]                 = dir;
    assign at_target[i]                 = (speed == tgt_mag) && (dir == tgt_dir);
  end

endmodule
